// File: rtl/ids_chebyshev_sequencer.sv
// Horner-order polynomial evaluation sequencer driving an external
// multiply-accumulate datapath.
//
// Ports:
//   clock, resetn            rising-edge clock, async active-low reset
//   in_valid/in_ready/in_data    operand x handshake
//   out_valid/out_ready/out_data polynomial result handshake
//   cfg_we/cfg_addr/cfg_wdata    coefficient c[k] / degree register write
//   cfg_err                      one-cycle pulse when a write is rejected
//   dp_x, dp_seed, dp_coeff      datapath operands (x, c[N], c[k])
//   dp_first, dp_issue           step control pulses to the datapath
//   dp_result                    datapath result, valid PIPE_LAT cycles
//                                after dp_issue
module ids_chebyshev_sequencer #(
    parameter int WORD_LENGTH  = 16,
    parameter int COEFF_LENGTH = 16,
    parameter int DEGREE_MAX   = 3,
    parameter int PIPE_LAT     = 2
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_LENGTH-1:0]           in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_LENGTH-1:0]           out_data,
    input  logic                             cfg_we,
    input  logic [$clog2(DEGREE_MAX+2)-1:0]  cfg_addr,
    input  logic [COEFF_LENGTH-1:0]          cfg_wdata,
    output logic                             cfg_err,
    output logic [WORD_LENGTH-1:0]           dp_x,
    output logic [COEFF_LENGTH-1:0]          dp_seed,
    output logic [COEFF_LENGTH-1:0]          dp_coeff,
    output logic                             dp_first,
    output logic                             dp_issue,
    input  logic [WORD_LENGTH-1:0]           dp_result
);

    localparam int ADDR_W = $clog2(DEGREE_MAX + 2);
    localparam int DEG_W  = (DEGREE_MAX > 0) ? $clog2(DEGREE_MAX + 1) : 1;
    localparam int CNT_W  = $clog2(PIPE_LAT + 1);

    localparam logic [ADDR_W-1:0]       DEG_ADDR  = ADDR_W'(DEGREE_MAX + 1);
    localparam logic [COEFF_LENGTH-1:0] DEG_LIMIT = COEFF_LENGTH'(DEGREE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state;
    logic [COEFF_LENGTH-1:0] coeff [DEGREE_MAX+1];
    logic [DEG_W-1:0]        degree;
    logic [DEG_W-1:0]        k;
    logic [CNT_W-1:0]        cnt;

    logic                    idle;
    logic                    cfg_ok_coeff;
    logic                    cfg_ok_deg;
    logic                    cfg_bad;
    logic [DEG_W-1:0]        deg_new;
    logic [DEG_W-1:0]        k_first;
    logic [DEG_W-1:0]        k_dn;
    logic [COEFF_LENGTH-1:0] c_new [DEGREE_MAX+1];

    assign idle         = (state == IDLE);
    assign cfg_ok_coeff = cfg_we && idle && (cfg_addr < DEG_ADDR);
    assign cfg_ok_deg   = cfg_we && idle && (cfg_addr == DEG_ADDR)
                          && (cfg_wdata <= DEG_LIMIT);
    assign cfg_bad      = cfg_we && !(cfg_ok_coeff || cfg_ok_deg);

    // Register-file view with this cycle's write forwarded, so a write and
    // an accept on the same edge evaluate with the new value.
    assign deg_new = cfg_ok_deg ? cfg_wdata[DEG_W-1:0] : degree;
    assign k_first = deg_new - DEG_W'(1);
    assign k_dn    = k - DEG_W'(1);

    always_comb begin
        for (int i = 0; i <= DEGREE_MAX; i++) begin
            c_new[i] = coeff[i];
            if (cfg_ok_coeff && (cfg_addr == ADDR_W'(i))) begin
                c_new[i] = cfg_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
            dp_x      <= '0;
            dp_seed   <= '0;
            dp_coeff  <= '0;
            dp_first  <= 1'b0;
            dp_issue  <= 1'b0;
            degree    <= DEG_W'(DEGREE_MAX);
            k         <= '0;
            cnt       <= '0;
            for (int i = 0; i <= DEGREE_MAX; i++) begin
                coeff[i] <= '0;
            end
        end else begin
            cfg_err  <= cfg_bad;
            dp_issue <= 1'b0;
            dp_first <= 1'b0;
            degree   <= deg_new;
            for (int i = 0; i <= DEGREE_MAX; i++) begin
                coeff[i] <= c_new[i];
            end

            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dp_x     <= in_data;
                        dp_seed  <= c_new[deg_new];
                        k        <= k_first;
                        if (deg_new != '0) begin
                            dp_issue <= 1'b1;
                            dp_first <= 1'b1;
                            dp_coeff <= c_new[k_first];
                            state    <= ISSUE;
                        end else begin
                            out_data  <= c_new[0][WORD_LENGTH-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_W'(PIPE_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    // Result is sampled on the edge where the count expires.
                    if (cnt == CNT_W'(1)) begin
                        if (k == '0) begin
                            out_data  <= dp_result;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            k        <= k_dn;
                            dp_coeff <= coeff[k_dn];
                            dp_issue <= 1'b1;
                            state    <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ids_chebyshev_sequencer.sv
// Scoreboard bench for ids_chebyshev_sequencer with a behavioural
// datapath model (acc*x+c, PIPE_LAT latency) and a Horner reference model.
module tb_ids_chebyshev_sequencer;

    localparam int W  = 16;
    localparam int CL = 16;
    localparam int DM = 3;
    localparam int PL = 2;
    localparam int AW = $clog2(DM + 2);

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CL-1:0] cfg_wdata;
    logic          cfg_err;
    logic [W-1:0]  dp_x;
    logic [CL-1:0] dp_seed;
    logic [CL-1:0] dp_coeff;
    logic          dp_first;
    logic          dp_issue;
    logic [W-1:0]  dp_result;

    ids_chebyshev_sequencer #(
        .WORD_LENGTH (W),
        .COEFF_LENGTH(CL),
        .DEGREE_MAX  (DM),
        .PIPE_LAT    (PL)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_err  (cfg_err),
        .dp_x     (dp_x),
        .dp_seed  (dp_seed),
        .dp_coeff (dp_coeff),
        .dp_first (dp_first),
        .dp_issue (dp_issue),
        .dp_result(dp_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Datapath model: multiply-accumulate, result PL cycles after dp_issue.
    logic [W-1:0] dp_acc;
    logic [W-1:0] dp_pipe [PL];
    logic [W-1:0] dp_v;
    assign dp_v = (dp_first ? dp_seed[W-1:0] : dp_acc) * dp_x
                  + dp_coeff[W-1:0];
    assign dp_result = dp_pipe[PL-1];
    always @(posedge clock) begin
        if (dp_issue) dp_acc <= dp_v;
        dp_pipe[0] <= dp_v;
        for (int i = 1; i < PL; i++) dp_pipe[i] <= dp_pipe[i-1];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout at cycle %0d", name, cyc);
    endtask

    // Reference model state
    logic [CL-1:0] m_c [DM+1];
    int            m_deg;

    function automatic logic [W-1:0] horner(input int deg,
                                            input logic [W-1:0] x);
        logic [W-1:0] acc;
        acc = m_c[deg][W-1:0];
        for (int j = deg - 1; j >= 0; j--) acc = acc * x + m_c[j][W-1:0];
        return acc;
    endfunction

    function automatic bit model_cfg(input logic [AW-1:0] a,
                                     input logic [CL-1:0] d, input bit idle);
        bit err;
        err = !idle || (int'(a) > DM + 1)
              || ((int'(a) == DM + 1) && (int'(d) > DM));
        if (!err) begin
            if (int'(a) <= DM) m_c[a] = d;
            else m_deg = int'(d);
        end
        return err;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= DM; i++) m_c[i] = '0;
        m_deg = DM;
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           rise;
    } exp_t;
    exp_t sbq[$];

    logic [CL-1:0] iss_q[$];
    logic          first_q[$];
    always @(negedge clock) begin
        if (resetn && dp_issue) begin
            iss_q.push_back(dp_coeff);
            first_q.push_back(dp_first);
        end
    end

    // Monitor: latency on out_valid rise, data on handshake, stability
    // while stalled.
    logic [W-1:0] last_out;
    initial begin
        bit           prev_ov;
        bit           held;
        logic [W-1:0] held_data;
        exp_t         e;
        prev_ov  = 0;
        held     = 0;
        last_out = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prev_ov = 0;
                held    = 0;
            end else begin
                if (out_valid && held) begin
                    check("out_data_stable", out_data, held_data);
                    check("in_ready_in_done", in_ready, 0);
                end
                if (out_valid && !prev_ov) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out_valid: got %0d expected none",
                                 out_data);
                    end else begin
                        check("latency", cyc, sbq[0].rise);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("out_data", out_data, e.data);
                    end
                    last_out = out_data;
                    held     = 0;
                end else if (out_valid) begin
                    held      = 1;
                    held_data = out_data;
                end
                prev_ov = out_valid;
            end
        end
    end

    bit rdy_rand = 0;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clock);
        while (in_ready !== 1'b1) begin
            @(negedge clock);
            if (++t > 2000) begin
                timeout("wait_ready");
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clock);
        while (!(sbq.size() == 0 && in_ready === 1'b1)) begin
            @(negedge clock);
            if (++t > 2000) begin
                timeout("wait_drain");
                break;
            end
        end
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [CL-1:0] d,
                             input bit idle);
        bit e;
        @(posedge clock);
        #1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        e = model_cfg(a, d, idle);
        check("cfg_err", cfg_err, e);
        @(posedge clock);
        #1;
        check("cfg_err_pulse", cfg_err, 0);
    endtask

    task automatic send(input logic [W-1:0] x, input bit with_cfg,
                        input logic [AW-1:0] a, input logic [CL-1:0] d,
                        output int a_cyc);
        int t = 0;
        bit ok = 1;
        bit e;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = x;
        if (with_cfg) begin
            cfg_we    = 1'b1;
            cfg_addr  = a;
            cfg_wdata = d;
        end
        @(negedge clock);
        while (in_ready !== 1'b1) begin
            @(negedge clock);
            if (++t > 200) begin
                timeout("accept");
                ok = 0;
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        a_cyc    = cyc;
        if (with_cfg) e = model_cfg(a, d, 1);
        if (ok) sbq.push_back('{data: horner(m_deg, x),
                                rise: cyc + m_deg * (PL + 1)});
    endtask

    initial begin
        int a;
        int t;
        logic [AW-1:0] ra;
        logic [CL-1:0] rd;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_dp_x", dp_x, 0);
        check("rst_dp_seed", dp_seed, 0);
        check("rst_dp_coeff", dp_coeff, 0);
        check("rst_dp_first", dp_first, 0);
        check("rst_dp_issue", dp_issue, 0);
        check("rst_cfg_err", cfg_err, 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("in_ready_after_release", in_ready, 1);

        // Default degree and zeroed coefficients
        send(16'd9, 0, '0, '0, a);
        wait_drain();
        check("zero_coeff_result", last_out, 0);

        // c = 1,2,3,4, degree 3, x = 2
        for (int i = 0; i <= DM; i++) cfg_write(AW'(i), CL'(i + 1), 1);
        iss_q.delete();
        first_q.delete();
        send(16'd2, 0, '0, '0, a);
        repeat (5) @(negedge clock);
        check("dp_x_hold", dp_x, 2);
        check("dp_seed_hold", dp_seed, 4);
        wait_drain();
        check("poly49", last_out, 49);
        check("issue_count", iss_q.size(), 3);
        if (iss_q.size() == 3) begin
            check("dp_coeff0", iss_q[0], 3);
            check("dp_coeff1", iss_q[1], 2);
            check("dp_coeff2", iss_q[2], 1);
            check("dp_first0", first_q[0], 1);
            check("dp_first1", first_q[1], 0);
        end

        // Degree 0
        cfg_write(AW'(DM + 1), CL'(0), 1);
        cfg_write(AW'(0), CL'(7), 1);
        iss_q.delete();
        send(16'd5, 0, '0, '0, a);
        wait_drain();
        check("deg0_result", last_out, 7);
        check("deg0_no_issue", iss_q.size(), 0);

        // Out-of-range degree write is rejected
        cfg_write(AW'(DM + 1), CL'(3), 1);
        cfg_write(AW'(DM + 1), CL'(5), 1);
        send(16'd2, 0, '0, '0, a);
        wait_drain();
        check("deg_reject_result", last_out, 55);

        // Write and accept on the same edge
        send(16'd2, 1, AW'(0), CL'(1), a);
        check("cfg_with_accept_err", cfg_err, 0);
        wait_drain();
        check("cfg_with_accept", last_out, 49);

        // Output stall
        out_ready = 1'b0;
        send(16'd3, 0, '0, '0, a);
        t = 0;
        @(negedge clock);
        while (out_valid !== 1'b1) begin
            @(negedge clock);
            if (++t > 200) begin
                timeout("stall_wait");
                break;
            end
        end
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("accept_after_handshake", in_ready, 1);
        check("out_valid_dropped", out_valid, 0);
        check("stall_result", last_out, 142);

        // Config write while busy
        send(16'd2, 0, '0, '0, a);
        cfg_write(AW'(1), CL'(99), 0);
        wait_drain();
        check("busy_write_result", last_out, 49);

        // Reset during the second WAIT
        send(16'd2, 0, '0, '0, a);
        t = 0;
        @(negedge clock);
        while (cyc < a + 4) begin
            @(negedge clock);
            if (++t > 50) break;
        end
        #2;
        resetn = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_data", out_data, 0);
        check("abort_dp_issue", dp_issue, 0);
        check("abort_dp_x", dp_x, 0);
        check("abort_dp_coeff", dp_coeff, 0);
        repeat (2) @(negedge clock);
        #2;
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        send(16'd6, 0, '0, '0, a);
        wait_drain();
        check("post_reset_result", last_out, 0);

        // Randomized traffic
        rdy_rand = 1;
        for (int it = 0; it < 40; it++) begin
            wait_ready();
            if ($urandom_range(0, 2) == 0) begin
                ra = AW'($urandom_range(0, DM + 1));
                if (int'(ra) == DM + 1) rd = CL'($urandom_range(0, DM + 2));
                else rd = CL'($urandom);
                cfg_write(ra, rd, 1);
            end
            send(W'($urandom), 0, '0, '0, a);
        end
        rdy_rand = 0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
